// File: rtl/adder_chk_pkg.sv
// Shared constants and types for the ripple-adder sweep checker.
// Contents:
//   DEF_WIDTH  - default operand width
//   IDX_W      - sweep index width {cin,a,b} for the default width
//   N_VEC      - vectors per complete sweep for the default width
//   CNT_W      - width of the check counter
//   ERR_W      - width of the (saturating) error counter
//   state_e    - checker FSM states
//   n_vec()    - vectors per sweep for an arbitrary operand width
package adder_chk_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int IDX_W     = 2 * DEF_WIDTH + 1;
    localparam int N_VEC     = 2 * (2 ** DEF_WIDTH) * (2 ** DEF_WIDTH);
    localparam int CNT_W     = $clog2(N_VEC + 1);
    localparam int ERR_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of vectors in an exhaustive {cin,a,b} sweep of width w.
    function automatic int n_vec(input int w);
        return 2 * (2 ** w) * (2 ** w);
    endfunction

endpackage

// File: rtl/adder_ref_model.sv
// Golden reference for a WIDTH-bit adder with carry-in.
// Ports:
//   i_a, i_b    - operands (WIDTH bits)
//   i_cin       - carry-in
//   o_sum_full  - {cout,sum}, WIDTH+1 bits, purely combinational
module adder_ref_model
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH:0]   o_sum_full
);

    // Zero-extend every term so the carry lands in the top bit.
    assign o_sum_full = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/adder_sweep_checker.sv
// Response checker for an exhaustive {cin,a,b} sweep of a ripple adder.
// Compares each valid vector against a golden sum, checks sweep order,
// counts checks/errors, captures the first failing vector and reports
// pass/fail once every vector of the sweep has been seen.
// Ports:
//   i_clk, i_reset         - clock, synchronous active-high reset
//   i_start                - begin a sweep check (ignored while running)
//   i_vld                  - i_a/i_b/i_cin/i_sum/i_cout hold a settled vector
//   i_a, i_b, i_cin        - applied operands / carry-in
//   i_sum, i_cout          - adder response
//   o_busy, o_done, o_pass - status (all registered)
//   o_check_count          - vectors checked since start
//   o_err_count            - arithmetic mismatches (saturating)
//   o_order_err            - sticky out-of-order flag
//   o_fe_*                 - first failing vector and its response
module adder_sweep_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                                    i_clk,
    input  logic                                    i_reset,
    input  logic                                    i_start,
    input  logic                                    i_vld,
    input  logic [WIDTH-1:0]                        i_a,
    input  logic [WIDTH-1:0]                        i_b,
    input  logic                                    i_cin,
    input  logic [WIDTH-1:0]                        i_sum,
    input  logic                                    i_cout,
    output logic                                    o_busy,
    output logic                                    o_done,
    output logic                                    o_pass,
    output logic [$clog2(n_vec(WIDTH) + 1)-1:0]     o_check_count,
    output logic [ERR_W-1:0]                        o_err_count,
    output logic                                    o_order_err,
    output logic [WIDTH-1:0]                        o_fe_a,
    output logic [WIDTH-1:0]                        o_fe_b,
    output logic                                    o_fe_cin,
    output logic [WIDTH-1:0]                        o_fe_sum,
    output logic                                    o_fe_cout
);

    localparam int L_NVEC  = n_vec(WIDTH);
    localparam int L_IDX_W = 2 * WIDTH + 1;
    localparam int L_CNT_W = $clog2(L_NVEC + 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [L_CNT_W-1:0] r_check_count;
    logic [ERR_W-1:0]   r_err_count;
    logic               r_order_err;
    logic [L_IDX_W-1:0] r_exp_idx;
    logic [WIDTH-1:0]   r_fe_a;
    logic [WIDTH-1:0]   r_fe_b;
    logic               r_fe_cin;
    logic [WIDTH-1:0]   r_fe_sum;
    logic               r_fe_cout;

    logic [WIDTH:0]     w_golden;
    logic               w_mismatch;
    logic [L_IDX_W-1:0] w_idx;
    logic [L_IDX_W-1:0] w_idx_inc;
    logic [L_CNT_W-1:0] w_cnt_inc;
    logic               w_last;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_order_next;
    logic               w_first_err;

    adder_ref_model #(
        .WIDTH      (WIDTH)
    ) u_ref (
        .i_a        (i_a),
        .i_b        (i_b),
        .i_cin      (i_cin),
        .o_sum_full (w_golden)
    );

    // Sweep order is cin outer, a middle, b inner, so the index is a plain
    // concatenation; the increment wraps naturally because N_VEC = 2**IDX_W.
    assign w_idx      = {i_cin, i_a, i_b};
    assign w_idx_inc  = w_idx + {{(L_IDX_W-1){1'b0}}, 1'b1};
    assign w_mismatch = ({i_cout, i_sum} != w_golden);
    assign w_cnt_inc  = r_check_count + {{(L_CNT_W-1){1'b0}}, 1'b1};
    assign w_last     = (w_cnt_inc == L_CNT_W'(L_NVEC));
    // The error counter only leaves zero on a mismatch and saturates rather
    // than wrapping, so zero means no failure has been captured yet.
    assign w_first_err = w_mismatch && (r_err_count == {ERR_W{1'b0}});

    // Next error count and order flag for a vector accepted this cycle.
    always_comb begin
        w_err_next   = r_err_count;
        w_order_next = r_order_err;
        if (w_mismatch && (r_err_count != {ERR_W{1'b1}})) begin
            w_err_next = r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
        end else begin
            w_err_next = r_err_count;
        end
        if (w_idx != r_exp_idx) begin
            w_order_next = 1'b1;
        end else begin
            w_order_next = r_order_err;
        end
    end

    // Checker FSM, counters and first-error capture.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_check_count <= {L_CNT_W{1'b0}};
            r_err_count   <= {ERR_W{1'b0}};
            r_order_err   <= 1'b0;
            r_exp_idx     <= {L_IDX_W{1'b0}};
            r_fe_a        <= {WIDTH{1'b0}};
            r_fe_b        <= {WIDTH{1'b0}};
            r_fe_cin      <= 1'b0;
            r_fe_sum      <= {WIDTH{1'b0}};
            r_fe_cout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state       <= S_RUN;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_check_count <= {L_CNT_W{1'b0}};
                        r_err_count   <= {ERR_W{1'b0}};
                        r_order_err   <= 1'b0;
                        r_exp_idx     <= {L_IDX_W{1'b0}};
                        r_fe_a        <= {WIDTH{1'b0}};
                        r_fe_b        <= {WIDTH{1'b0}};
                        r_fe_cin      <= 1'b0;
                        r_fe_sum      <= {WIDTH{1'b0}};
                        r_fe_cout     <= 1'b0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                S_RUN: begin
                    if (i_vld) begin
                        r_check_count <= w_cnt_inc;
                        r_err_count   <= w_err_next;
                        r_order_err   <= w_order_next;
                        // Resynchronise on the received index so a single
                        // skipped vector raises only one order violation.
                        r_exp_idx     <= w_idx_inc;
                        if (w_first_err) begin
                            r_fe_a    <= i_a;
                            r_fe_b    <= i_b;
                            r_fe_cin  <= i_cin;
                            r_fe_sum  <= i_sum;
                            r_fe_cout <= i_cout;
                        end else begin
                            r_fe_a    <= r_fe_a;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == {ERR_W{1'b0}}) && !w_order_next;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_pass        = r_pass;
    assign o_check_count = r_check_count;
    assign o_err_count   = r_err_count;
    assign o_order_err   = r_order_err;
    assign o_fe_a        = r_fe_a;
    assign o_fe_b        = r_fe_b;
    assign o_fe_cin      = r_fe_cin;
    assign o_fe_sum      = r_fe_sum;
    assign o_fe_cout     = r_fe_cout;

endmodule
